// File: rtl/main_control_pipe.sv
// rtl/main_control_pipe.sv - registered ID-stage main control: decode, branch resolve, stall bubbles, HALT drain/resume FSM
// Optional retire/taken counters are built only when MAIN_CTRL_STATS_EN is defined.
module main_control_pipe #(
    parameter int              DATA_W       = 32,
    parameter int              OP_W         = 6,
    parameter int              FUNCT_W      = 6,
    parameter int              CTRL_W       = 15,
    parameter logic [OP_W-1:0] HALT_OP      = OP_W'(6'h3F),
    parameter int              DRAIN_CYCLES = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_stall,
    input  logic               i_resume,
    input  logic [OP_W-1:0]    i_op,
    input  logic [FUNCT_W-1:0] i_funct,
    input  logic [DATA_W-1:0]  i_bus_a,
    input  logic [DATA_W-1:0]  i_bus_b,
    output logic [CTRL_W-1:0]  o_ctrl_regs,
    output logic               o_valid,
    output logic               o_flush,
    output logic               o_halted,
    output logic [31:0]        o_instr_count,
    output logic [31:0]        o_taken_count
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'h03);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'h05);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'h0A);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'h0C);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'h0D);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(6'h0E);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'h0F);
    localparam logic [OP_W-1:0] OP_LB    = OP_W'(6'h20);
    localparam logic [OP_W-1:0] OP_LH    = OP_W'(6'h21);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_LBU   = OP_W'(6'h24);
    localparam logic [OP_W-1:0] OP_LHU   = OP_W'(6'h25);
    localparam logic [OP_W-1:0] OP_LWU   = OP_W'(6'h27);
    localparam logic [OP_W-1:0] OP_SB    = OP_W'(6'h28);
    localparam logic [OP_W-1:0] OP_SH    = OP_W'(6'h29);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

    localparam logic [FUNCT_W-1:0] FN_SLL  = FUNCT_W'(6'h00);
    localparam logic [FUNCT_W-1:0] FN_SRL  = FUNCT_W'(6'h02);
    localparam logic [FUNCT_W-1:0] FN_SRA  = FUNCT_W'(6'h03);
    localparam logic [FUNCT_W-1:0] FN_JR   = FUNCT_W'(6'h08);
    localparam logic [FUNCT_W-1:0] FN_JALR = FUNCT_W'(6'h09);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] drain_cnt;
    logic [14:0]      dec_word;
    logic             operands_eq;
    logic             issue_decode;
    logic             issue_flush;

    function automatic logic [14:0] pack_ctrl(
        input logic       next_pc_src,
        input logic [1:0] jmp,
        input logic       reg_write,
        input logic [1:0] reg_dst,
        input logic [1:0] mem_to_reg,
        input logic       mem_write,
        input logic       alu_src_a,
        input logic [1:0] alu_src_b,
        input logic [2:0] alu_op
    );
        return {next_pc_src, jmp, reg_write, reg_dst, mem_to_reg,
                mem_write, alu_src_a, alu_src_b, alu_op};
    endfunction

    assign operands_eq = (i_bus_a == i_bus_b);

    // reg_dst: 00 rt, 01 rd, 10 ra; mem_to_reg: 00 alu, 01 mem, 10 pc+4;
    // alu_src_b: 00 rt, 01 sext imm, 10 zext imm, 11 imm<<16; alu_src_a=1 selects shamt.
    always_comb begin
        dec_word = '0;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FN_JR:   dec_word = pack_ctrl(1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000);
                    FN_JALR: dec_word = pack_ctrl(1'b1, 2'b10, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0, 2'b00, 3'b000);
                    FN_SLL, FN_SRL, FN_SRA:
                             dec_word = pack_ctrl(1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 2'b00, 3'b010);
                    default: dec_word = pack_ctrl(1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 3'b010);
                endcase
            end
            OP_J:    dec_word = pack_ctrl(1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000);
            OP_JAL:  dec_word = pack_ctrl(1'b1, 2'b01, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 2'b00, 3'b000);
            OP_BEQ:  dec_word = pack_ctrl(operands_eq, {2{operands_eq}},
                                          1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b001);
            OP_BNE:  dec_word = pack_ctrl(!operands_eq, {2{!operands_eq}},
                                          1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b001);
            OP_ADDI: dec_word = pack_ctrl(1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'b000);
            OP_SLTI: dec_word = pack_ctrl(1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'b011);
            OP_ANDI: dec_word = pack_ctrl(1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 3'b100);
            OP_ORI:  dec_word = pack_ctrl(1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 3'b101);
            OP_XORI: dec_word = pack_ctrl(1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 3'b110);
            OP_LUI:  dec_word = pack_ctrl(1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 3'b111);
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU:
                     dec_word = pack_ctrl(1'b0, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 2'b01, 3'b000);
            OP_SB, OP_SH, OP_SW:
                     dec_word = pack_ctrl(1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 3'b000);
            default: dec_word = '0;
        endcase
    end

    // Stall outranks everything, including HALT and taken transfers.
    assign issue_decode = (state == S_RUN) && i_valid && !i_stall && (i_op != HALT_OP);
    assign issue_flush  = issue_decode && dec_word[14];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_RUN;
            drain_cnt   <= '0;
            o_ctrl_regs <= '0;
            o_valid     <= 1'b0;
            o_flush     <= 1'b0;
            o_halted    <= 1'b0;
        end else begin
            o_ctrl_regs <= issue_decode ? CTRL_W'(dec_word) : '0;
            o_valid     <= issue_decode;
            o_flush     <= issue_flush;
            case (state)
                S_RUN: begin
                    if (i_valid && !i_stall && (i_op == HALT_OP)) begin
                        state     <= S_DRAIN;
                        drain_cnt <= CNT_W'(DRAIN_CYCLES);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt <= CNT_W'(1)) begin
                        state    <= S_HALTED;
                        o_halted <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                S_HALTED: begin
                    if (i_resume) begin
                        state    <= S_RUN;
                        o_halted <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_RUN;
                    o_halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef MAIN_CTRL_STATS_EN
    logic [31:0] instr_count;
    logic [31:0] taken_count;

    // Counters saturate rather than wrap so long runs never report a small value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            instr_count <= '0;
            taken_count <= '0;
        end else begin
            if (issue_decode && (instr_count != 32'hFFFF_FFFF))
                instr_count <= instr_count + 32'd1;
            if (issue_flush && (taken_count != 32'hFFFF_FFFF))
                taken_count <= taken_count + 32'd1;
        end
    end

    assign o_instr_count = instr_count;
    assign o_taken_count = taken_count;
`else
    assign o_instr_count = 32'd0;
    assign o_taken_count = 32'd0;
`endif

endmodule
